fetch_ctrl: RTL

Sequencing controller for the program counter register. It arbitrates every PC redirect source (trap, mret, branch/jump), boot, data-hazard stall, instruction-memory backpressure and debug halt. From these it drives the PC's jump address, select and stop inputs. It also owns the exception PC register and the front-end flush signal; it sits between execute/CSR logic and the PC at the head of the fetch stage.

---
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect/stall request bundle and PC control outputs of fetch_ctrl
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              branch_req_i;
    logic [ADDR_W-1:0] branch_addr_i;
    logic              trap_req_i;
    logic [ADDR_W-1:0] trap_vec_i;
    logic [ADDR_W-1:0] trap_pc_i;
    logic              mret_req_i;
    logic              hazard_stall_i;
    logic              imem_ready_i;
    logic              halt_req_i;
    logic              resume_i;

    logic [ADDR_W-1:0] pc_jump_addr_o;
    logic              pc_sel_o;
    logic              pc_stop_o;
    logic              flush_o;
    logic [ADDR_W-1:0] epc_o;
    logic              halted_o;
    logic              accept_o;

    modport master (
        output branch_req_i, branch_addr_i, trap_req_i, trap_vec_i, trap_pc_i,
               mret_req_i, hazard_stall_i, imem_ready_i, halt_req_i, resume_i,
        input  pc_jump_addr_o, pc_sel_o, pc_stop_o, flush_o, epc_o, halted_o, accept_o
    );

    modport slave (
        input  branch_req_i, branch_addr_i, trap_req_i, trap_vec_i, trap_pc_i,
               mret_req_i, hazard_stall_i, imem_ready_i, halt_req_i, resume_i,
        output pc_jump_addr_o, pc_sel_o, pc_stop_o, flush_o, epc_o, halted_o, accept_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing controller: redirect arbitration, stalls, flush and debug halt
module fetch_ctrl #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] START_ADDR   = 32'h0000_0000,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    fetch_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_MEM,
        ST_FLUSH,
        ST_HALT
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;

    logic [ADDR_W-1:0] jump_addr;
    logic              sel;
    logic              stop;
    logic              flush;
    logic              halted;
    logic              accept;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Fixed priority trap > mret > branch; losers are simply dropped.
    always_comb begin
        redirect = bus.trap_req_i | bus.mret_req_i | bus.branch_req_i;
        if (bus.trap_req_i) begin
            target = align(bus.trap_vec_i);
        end else if (bus.mret_req_i) begin
            target = align(epc_q);
        end else begin
            target = align(bus.branch_addr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_BOOT;
            epc_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        jump_addr = align(pend_q);
        sel       = 1'b0;
        stop      = 1'b0;
        flush     = 1'b0;
        halted    = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                sel       = 1'b1;
                jump_addr = align(START_ADDR);
                flush     = 1'b1;
                state_d   = ST_RUN;
            end

            ST_RUN: begin
                if (redirect) begin
                    accept = 1'b1;
                    flush  = 1'b1;
                    if (bus.trap_req_i) begin
                        epc_d = bus.trap_pc_i;
                    end
                    if (bus.imem_ready_i) begin
                        sel       = 1'b1;
                        jump_addr = target;
                        cnt_d     = CNT_INIT;
                        state_d   = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                    end else begin
                        // Memory busy: hold the target until a fetch can be issued.
                        pend_d  = target;
                        stop    = 1'b1;
                        state_d = ST_WAIT_MEM;
                    end
                end else begin
                    stop = bus.hazard_stall_i | ~bus.imem_ready_i;
                    if (bus.halt_req_i) begin
                        stop    = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end

            ST_WAIT_MEM: begin
                flush = 1'b1;
                if (bus.imem_ready_i) begin
                    sel       = 1'b1;
                    jump_addr = align(pend_q);
                    cnt_d     = CNT_INIT;
                    state_d   = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                end else begin
                    stop = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Requests seen here come from wrong-path instructions and are ignored.
                flush = 1'b1;
                stop  = ~bus.imem_ready_i;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                stop   = 1'b1;
                halted = 1'b1;
                if (bus.resume_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        bus.epc_o = epc_q;
        if (rst_i) begin
            bus.pc_jump_addr_o = align(START_ADDR);
            bus.pc_sel_o       = 1'b0;
            bus.pc_stop_o      = 1'b1;
            bus.flush_o        = 1'b1;
            bus.halted_o       = 1'b0;
            bus.accept_o       = 1'b0;
        end else begin
            bus.pc_jump_addr_o = jump_addr;
            bus.pc_sel_o       = sel;
            bus.pc_stop_o      = stop;
            bus.flush_o        = flush;
            bus.halted_o       = halted;
            bus.accept_o       = accept;
        end
    end
endmodule
